// File: rtl/pc_com_pilha.sv
// Program counter with enable, op decoder, return-address stack and sticky
// overflow/underflow flag.
// Ports: clk, reset (sync, active-high), en, op[2:0], alvo[WIDTH-1:0] in;
//        pc, profundidade, pilha_cheia, pilha_vazia, erro out.
module pc_com_pilha #(
  parameter int                 WIDTH       = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0]   RESET_ADDR  = '0,
  parameter int                 STEP        = 1,
  localparam int                CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alvo,
  output logic [WIDTH-1:0] pc,
  output logic [CW-1:0]    profundidade,
  output logic             pilha_cheia,
  output logic             pilha_vazia,
  output logic             erro
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_JUMP = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_BREL = 3'd5;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             erro_q, erro_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic             push;
  logic             full;
  logic             empty;

  assign pc_inc = pc_q + WIDTH'(STEP);
  assign full   = (cnt_q == CW'(STACK_DEPTH));
  assign empty  = (cnt_q == '0);

  // Top-of-stack mux; entry cnt_q-1 holds the most recent return address.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    erro_d = erro_q;
    push   = 1'b0;
    if (en) begin
      case (op)
        OP_HOLD: ;
        OP_INC:  pc_d = pc_inc;
        OP_JUMP: pc_d = alvo;
        OP_CALL: begin
          if (full) begin
            erro_d = 1'b1;
          end else begin
            push  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            pc_d  = alvo;
          end
        end
        OP_RET: begin
          if (empty) begin
            erro_d = 1'b1;
          end else begin
            pc_d  = top;
            cnt_d = cnt_q - CW'(1);
          end
        end
        // WIDTH-bit add of the offset equals sign-extended add mod 2^WIDTH.
        OP_BREL: pc_d = pc_q + alvo;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_ADDR;
      cnt_q  <= '0;
      erro_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      erro_q <= erro_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && cnt_q == CW'(i)) stack_q[i] <= pc_inc;
      end
    end
  end

  assign pc           = pc_q;
  assign profundidade = cnt_q;
  assign pilha_cheia  = full;
  assign pilha_vazia  = empty;
  assign erro         = erro_q;

endmodule
